// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter
//
// Shares the game core's work RAM port between the game CPU and the
// high-score save/restore engine. The core is stalled through PAUSE_N. The
// bus is given a few cycles to settle, then the RAM is granted to the
// high-score engine. When the engine is done, the core stays paused for a
// short hold time before it is released. This block also merges the user
// pause toggle and the OSD pause into pause_n. It drives the dim flag once
// the user has been paused for a long time.
//
// Ports:
//   clk_sys, reset                    system clock, synchronous active-high reset
//   hs_req / hs_gnt                   high-score engine RAM request / grant
//   hs_addr, hs_din, hs_we, hs_dout   high-score engine RAM port
//   cpu_addr, cpu_din, cpu_we, cpu_dout  game CPU RAM port
//   ram_addr, ram_din, ram_we, ram_dout  shared RAM port (1-cycle sync read)
//   user_pause                        debounced pause button level
//   osd_open, osd_pause_en            OSD visible / pause-on-OSD option
//   pause_n                           registered, active-low pause to core
//   dim                               registered, halve video intensity
module hs_ram_arbiter #(
    parameter int AW         = 16,
    parameter int SETTLE     = 4,
    parameter int HOLD       = 2,
    parameter int DIM_CYCLES = 400000000,
    parameter int CW         = 32
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          hs_req,
    output logic          hs_gnt,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_din,
    input  logic          hs_we,
    output logic [7:0]    hs_dout,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          cpu_we,
    output logic [7:0]    cpu_dout,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout,
    input  logic          user_pause,
    input  logic          osd_open,
    input  logic          osd_pause_en,
    output logic          pause_n,
    output logic          dim
);

    localparam int CNT_MAX = (SETTLE > HOLD) ? SETTLE : HOLD;
    localparam int CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'(SETTLE - 1);
    localparam logic [CNTW-1:0] HOLD_LOAD   = CNTW'(HOLD - 1);
    localparam logic [CW-1:0]   DIM_LIMIT   = CW'(DIM_CYCLES);

    typedef enum logic [1:0] {IDLE, STALL, GRANT, RELEASE} state_t;

    state_t          state, state_next;
    logic [CNTW-1:0] cnt, cnt_next;
    logic            toggle, toggle_next;
    logic            user_prev;
    logic [CW-1:0]   dim_cnt, dim_cnt_next;
    logic            arb_pause_next;

    // Arbiter next state.
    // A dropped request wins over an expiring settle count, so a short
    // request pulse never produces a grant.
    // Re-requesting during RELEASE goes straight back to GRANT. The core
    // has stayed paused, so the bus is already quiet.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (hs_req) begin
                    state_next = STALL;
                    cnt_next   = SETTLE_LOAD;
                end
            end
            STALL: begin
                if (!hs_req) begin
                    state_next = RELEASE;
                    cnt_next   = HOLD_LOAD;
                end else if (cnt == '0) begin
                    state_next = GRANT;
                end else begin
                    cnt_next = cnt - CNTW'(1);
                end
            end
            GRANT: begin
                if (!hs_req) begin
                    state_next = RELEASE;
                    cnt_next   = HOLD_LOAD;
                end
            end
            RELEASE: begin
                if (hs_req) begin
                    state_next = GRANT;
                end else if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNTW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pause sources and the dim timer.
    // The timer counts only while the toggle is already set. It stops at
    // the limit instead of wrapping. It clears on the same edge that clears
    // the toggle, so dim drops together with pause_n.
    always_comb begin
        arb_pause_next = (state_next != IDLE);
        toggle_next    = toggle ^ (user_pause & ~user_prev);
        if (!toggle_next) begin
            dim_cnt_next = '0;
        end else if (toggle && (dim_cnt < DIM_LIMIT)) begin
            dim_cnt_next = dim_cnt + CW'(1);
        end else begin
            dim_cnt_next = dim_cnt;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hs_gnt    <= 1'b0;
            pause_n   <= 1'b1;
            toggle    <= 1'b0;
            user_prev <= 1'b0;
            dim_cnt   <= '0;
            dim       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            hs_gnt    <= (state_next == GRANT);
            pause_n   <= ~(arb_pause_next | toggle_next | (osd_open & osd_pause_en));
            toggle    <= toggle_next;
            user_prev <= user_pause;
            dim_cnt   <= dim_cnt_next;
            dim       <= (dim_cnt_next >= DIM_LIMIT);
        end
    end

    // The RAM port mux follows the registered state. CPU writes are dropped
    // while the high-score engine owns the RAM.
    always_comb begin
        if (state == GRANT) begin
            ram_addr = hs_addr;
            ram_din  = hs_din;
            ram_we   = hs_we;
        end else begin
            ram_addr = cpu_addr;
            ram_din  = cpu_din;
            ram_we   = cpu_we;
        end
        hs_dout  = ram_dout;
        cpu_dout = ram_dout;
    end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb_hs_ram_arbiter
//
// Directed bench for hs_ram_arbiter with SETTLE=4, HOLD=2, DIM_CYCLES=100.
// Inputs change 1 ns after a rising edge. Outputs are checked at that same
// point, well away from the next active edge.
module tb_hs_ram_arbiter;

    localparam int AW = 16;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          hs_req;
    logic          hs_gnt;
    logic [AW-1:0] hs_addr;
    logic [7:0]    hs_din;
    logic          hs_we;
    logic [7:0]    hs_dout;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_we;
    logic [7:0]    cpu_dout;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout;
    logic          user_pause;
    logic          osd_open;
    logic          osd_pause_en;
    logic          pause_n;
    logic          dim;

    int total = 0;
    int bad   = 0;

    hs_ram_arbiter #(
        .AW(AW), .SETTLE(4), .HOLD(2), .DIM_CYCLES(100), .CW(32)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .hs_req(hs_req), .hs_gnt(hs_gnt),
        .hs_addr(hs_addr), .hs_din(hs_din), .hs_we(hs_we), .hs_dout(hs_dout),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .user_pause(user_pause), .osd_open(osd_open), .osd_pause_en(osd_pause_en),
        .pause_n(pause_n), .dim(dim)
    );

    always #5 clk_sys = ~clk_sys;

    // Advance n rising edges and leave time for the outputs to settle.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; hs_req = 1'b0; hs_addr = '0; hs_din = '0; hs_we = 1'b0;
        cpu_addr = 16'h0042; cpu_din = 8'h3C; cpu_we = 1'b1; ram_dout = 8'h5A;
        user_pause = 1'b0; osd_open = 1'b0; osd_pause_en = 1'b0;

        applyStimulus(3);
        checkOutput("rst_gnt", 32'(hs_gnt), 32'd0);
        checkOutput("rst_pause_n", 32'(pause_n), 32'd1);
        checkOutput("rst_dim", 32'(dim), 32'd0);
        reset = 1'b0;
        applyStimulus(2);

        // In idle the CPU drives the RAM, and read data reaches both ports.
        checkOutput("idle_addr", 32'(ram_addr), 32'h0042);
        checkOutput("idle_din", 32'(ram_din), 32'h3C);
        checkOutput("idle_we", 32'(ram_we), 32'd1);
        checkOutput("hs_dout", 32'(hs_dout), 32'h5A);
        checkOutput("cpu_dout", 32'(cpu_dout), 32'h5A);

        // Full request: pause_n falls, then the grant comes 4 edges later.
        hs_req = 1'b1;
        applyStimulus(1);
        checkOutput("stall_pause_n", 32'(pause_n), 32'd0);
        checkOutput("stall_gnt0", 32'(hs_gnt), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("stall_gnt%0d", i), 32'(hs_gnt), 32'd0);
        end
        applyStimulus(1);
        checkOutput("grant_gnt", 32'(hs_gnt), 32'd1);
        checkOutput("grant_pause_n", 32'(pause_n), 32'd0);

        hs_addr = 16'h1234; hs_din = 8'hA5; hs_we = 1'b1; cpu_we = 1'b1;
        #1;
        checkOutput("grant_addr", 32'(ram_addr), 32'h1234);
        checkOutput("grant_din", 32'(ram_din), 32'hA5);
        checkOutput("grant_we", 32'(ram_we), 32'd1);
        hs_we = 1'b0;
        #1;
        checkOutput("grant_cpu_we_blocked", 32'(ram_we), 32'd0);

        // Release: the grant drops at once, and pause_n rises 2 edges later.
        hs_req = 1'b0;
        applyStimulus(1);
        checkOutput("rel_gnt", 32'(hs_gnt), 32'd0);
        checkOutput("rel_addr", 32'(ram_addr), 32'h0042);
        checkOutput("rel_pause_n0", 32'(pause_n), 32'd0);
        applyStimulus(1);
        checkOutput("rel_pause_n1", 32'(pause_n), 32'd0);
        applyStimulus(1);
        checkOutput("rel_pause_n2", 32'(pause_n), 32'd1);

        // A two-cycle request pulse goes STALL then RELEASE, with no grant.
        hs_req = 1'b1;
        applyStimulus(1);
        checkOutput("pulse_gnt0", 32'(hs_gnt), 32'd0);
        applyStimulus(1);
        checkOutput("pulse_gnt1", 32'(hs_gnt), 32'd0);
        hs_req = 1'b0;
        applyStimulus(1);
        checkOutput("pulse_gnt2", 32'(hs_gnt), 32'd0);
        checkOutput("pulse_pause_n0", 32'(pause_n), 32'd0);
        checkOutput("pulse_we", 32'(ram_we), 32'd1);
        applyStimulus(1);
        checkOutput("pulse_pause_n1", 32'(pause_n), 32'd0);
        applyStimulus(1);
        checkOutput("pulse_pause_n2", 32'(pause_n), 32'd1);
        checkOutput("pulse_gnt_end", 32'(hs_gnt), 32'd0);

        // A re-request during RELEASE returns to GRANT with no settle wait.
        hs_req = 1'b1;
        applyStimulus(5);
        checkOutput("rereq_gnt_a", 32'(hs_gnt), 32'd1);
        hs_req = 1'b0;
        applyStimulus(1);
        checkOutput("rereq_gnt_drop", 32'(hs_gnt), 32'd0);
        hs_req = 1'b1;
        applyStimulus(1);
        checkOutput("rereq_gnt_b", 32'(hs_gnt), 32'd1);
        checkOutput("rereq_pause_n", 32'(pause_n), 32'd0);
        hs_req = 1'b0;
        applyStimulus(3);
        checkOutput("rereq_done_pause_n", 32'(pause_n), 32'd1);

        // User pause toggle and the dim timer.
        user_pause = 1'b1;
        applyStimulus(1);
        checkOutput("user_pause_n", 32'(pause_n), 32'd0);
        checkOutput("user_dim0", 32'(dim), 32'd0);
        user_pause = 1'b0;
        applyStimulus(99);
        checkOutput("user_dim99", 32'(dim), 32'd0);
        applyStimulus(1);
        checkOutput("user_dim100", 32'(dim), 32'd1);
        applyStimulus(5);
        checkOutput("user_dim_sat", 32'(dim), 32'd1);
        checkOutput("user_pause_n_hold", 32'(pause_n), 32'd0);
        osd_open = 1'b1;
        user_pause = 1'b1;
        applyStimulus(1);
        checkOutput("untoggle_pause_n", 32'(pause_n), 32'd1);
        checkOutput("untoggle_dim", 32'(dim), 32'd0);
        user_pause = 1'b0;
        osd_pause_en = 1'b1;
        applyStimulus(1);
        checkOutput("osd_pause_n", 32'(pause_n), 32'd0);
        checkOutput("osd_dim", 32'(dim), 32'd0);
        osd_open = 1'b0;
        applyStimulus(1);
        checkOutput("osd_off_pause_n", 32'(pause_n), 32'd1);

        // Reset while in GRANT.
        hs_req = 1'b1; hs_we = 1'b1; cpu_we = 1'b0;
        applyStimulus(5);
        checkOutput("pre_rst_gnt", 32'(hs_gnt), 32'd1);
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("mid_rst_gnt", 32'(hs_gnt), 32'd0);
        checkOutput("mid_rst_pause_n", 32'(pause_n), 32'd1);
        checkOutput("mid_rst_addr", 32'(ram_addr), 32'h0042);
        checkOutput("mid_rst_we", 32'(ram_we), 32'd0);
        checkOutput("mid_rst_dim", 32'(dim), 32'd0);
        reset = 1'b0; hs_req = 1'b0;
        applyStimulus(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the game core's work RAM port between the game CPU and the high-score save/restore engine.
- Stalls the core through its PAUSE_N input, waits for the bus to settle, grants the RAM to the high-score engine, then hands it back.
- Also owns the combined pause request (arbiter, user pause toggle, OSD pause) and the pause dim timer.
- Sits in the top level between hiscore, the game core RAM port and arcade_video.

Parameters:
AW, 16, RAM address width.
SETTLE, 4, cycles pause_n is held low before hs_gnt rises (>=1).
HOLD, 2, cycles pause_n stays low after hs_gnt falls (>=1).
DIM_CYCLES, 400000000, user-pause cycles before dim asserts (10 s at 40 MHz).
CW, 32, dim counter width.

Ports:
clk_sys  in  1  system clock, 40 MHz
reset  in  1  synchronous, active-high
hs_req  in  1  high-score engine requests RAM; level, held until done
hs_gnt  out  1  RAM owned by high-score engine
hs_addr  in  AW  high-score address
hs_din  in  8  high-score write data
hs_we  in  1  high-score write enable
hs_dout  out  8  RAM read data to high-score engine
cpu_addr  in  AW  CPU address
cpu_din  in  8  CPU write data
cpu_we  in  1  CPU write enable
cpu_dout  out  8  RAM read data to CPU
ram_addr  out  AW  to RAM
ram_din  out  8  to RAM
ram_we  out  1  to RAM
ram_dout  in  8  from RAM (synchronous, 1-cycle read)
user_pause  in  1  raw pause button level
osd_open  in  1  OSD visible
osd_pause_en  in  1  pause-on-OSD option enabled
pause_n  out  1  registered, to core PAUSE_N
dim  out  1  registered, halve video intensity

Behaviour:
- Reset values: state IDLE, hs_gnt=0, pause_n=1, dim=0, pause toggle=0, dim counter=0, settle/hold counter=0, button history=0.
- Reset mid-operation takes effect in one cycle from any state: grant drops and RAM returns to the CPU.
- FSM states: IDLE, STALL, GRANT, RELEASE.
  - IDLE: hs_req=1 → STALL; counter loads SETTLE-1.
  - STALL: counter decrements. At counter==0 → GRANT. hs_req=0 → RELEASE (counter loads HOLD-1).
  - GRANT: hs_gnt=1 (registered, so it rises on the edge entering GRANT). hs_req=0 → RELEASE; hs_gnt falls on that same edge; counter loads HOLD-1.
  - RELEASE: counter decrements; at counter==0 → IDLE. hs_req=1 → GRANT directly, with no new settle because the core is still paused.
- arb_pause = (state != IDLE).
- Timing: pause_n falls on the edge after IDLE samples hs_req. hs_gnt rises exactly SETTLE cycles after pause_n falls. pause_n rises HOLD cycles after hs_gnt falls, unless another pause source is active.
- Mux:
  - In GRANT: ram_addr/ram_din/ram_we = hs_addr/hs_din/hs_we; cpu_we is ignored.
  - In all other states: RAM is driven by cpu_*.
  - Mux is combinational from the registered state.
  - ram_dout is passed combinationally to both hs_dout and cpu_dout.
- User pause: the toggle flips on a rising edge of user_pause (a 1-cycle history register). The button is assumed to be already debounced.
- pause_n next = ~(arb_pause_next | toggle_next | (osd_open & osd_pause_en)). Arbiter, user and OSD pause are ORed; none overrides another.
- Dim timer:
  - Increments each cycle while the toggle is 1 and saturates at DIM_CYCLES (no wrap).
  - Clears to 0 on the cycle the toggle is 0.
  - dim = (count >= DIM_CYCLES), registered.
  - The arbiter and OSD pause never dim the video.
- hs_req asserted while the user pause is already active still runs the full SETTLE wait.

Test Plan:
- Reset, then hs_req=1 at cycle 10 → pause_n=0 from cycle 11, hs_gnt=1 at cycle 15 (SETTLE=4), state GRANT.
- In GRANT, hs_addr=0x1234, hs_we=1, hs_din=0xA5 with cpu_we=1 → ram_addr=0x1234, ram_din=0xA5, ram_we=1, CPU write not visible. Then hs_req=0 → hs_gnt=0 next edge, pause_n=1 two cycles later (HOLD=2).
- hs_req pulses for 2 cycles only → STALL→RELEASE, hs_gnt never 1, pause_n returns to 1 after HOLD, RAM always driven by cpu_*.
- hs_req drops then re-rises in RELEASE → GRANT next edge with no SETTLE wait; pause_n stays 0 throughout.
- user_pause rises with DIM_CYCLES=100 → pause_n=0, dim=1 after 100 cycles. Second rising edge → pause_n=1, dim=0 and counter 0 next cycle. osd_open=1, osd_pause_en=0 → pause_n unaffected.
- Assert reset while in GRANT → next edge hs_gnt=0, pause_n=1, ram_* follow cpu_*, dim=0.
